alu_issue_buffer: RTL and testbench
===================================

// Module: alu_issue_buffer
// PURPOSE
//  Producer side of the ISSUE_PACKET interface into the ALU functional units.
//  Accepts issued packets (operands already read from the physical regfile).
//  Buffers them in an in-order FIFO and presents one packet per cycle to the
//  ALU over a valid/ready handshake.
//  Sits between RS issue select / regfile read and the combinational ALU
//  adders, and decouples issue bandwidth from FU back-pressure.
// PARAMETERS
//  DEPTH   4   number of ISSUE_PACKET entries; power of two, >= 2
// PORTS
//  clock      in   1               single clock, rising edge
//  reset_n    in   1               asynchronous, active-low reset
//  in_valid   in   1               issue stage offers in_pack this cycle
//  in_pack    in   ISSUE_PACKET    packet incl. rs1_value/rs2_value and decoded_vals
//  in_ready   out  1               buffer can accept; registered, = (count < DEPTH)
//  squash     in   1               branch-mispredict flush; discards all entries
//  out_valid  out  1               out_pack holds a live packet; = (count != 0)
//  out_pack   out  ISSUE_PACKET    head entry, driven from storage (no input bypass)
//  out_ready  in   1               ALU consumes out_pack this cycle
//  count      out  $clog2(DEPTH+1) occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (reset_n low, async): head/tail pointers=0, count=0, in_ready=1,
//   out_valid=0, out_pack='0. Storage contents are don't-care but must not leak:
//   out_pack is forced to '0 whenever count==0.
//  Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are sampled on
//   the rising edge.
//  Latency: a packet pushed in cycle N is visible on out_pack/out_valid in cycle
//   N+1 at the earliest. There is no same-cycle flow-through.
//  in_ready depends only on state (count), never on out_ready. This means no
//   combinational path from the ALU side to the issue side.
//  Full (count==DEPTH): in_ready=0. A pop in that cycle frees a slot for N+1 only.
//  Empty (count==0): out_valid=0, out_pack='0. out_ready is ignored.
//  Simultaneous push+pop with 0<count<DEPTH: count is unchanged and both
//   pointers advance.
//  Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. count is kept
//   separately, so full and empty are unambiguous.
//  Order: strict FIFO; packets leave in push order. Payload is unmodified
//   bit-for-bit.
//  squash=1 at edge: pointers and count -> 0, same as reset. A push and a pop in
//   the same cycle are both discarded; the pop is treated as not having happened
//   for accounting. From cycle N+1: out_valid=0, in_ready=1.
//  Reset mid-operation: all in-flight entries are lost. The first push after
//   reset_n rises appears at N+1 as normal.
//  in_valid while in_ready=0: ignored. The issue stage must hold the packet.
// STRUCTURE
//  ISSUE_PACKET, DATA and the decoded-field types remain in sys_defs.svh.
//  Add `ALU_ISSUE_BUF_DEPTH (default 4) to sys_defs.svh. The top-level
//   instantiates with DEPTH(`ALU_ISSUE_BUF_DEPTH).
//  No sub-module: storage array, two pointers, count register, output mux.
//  Storage is flops, not SRAM, because DEPTH is small and the read must be
//   same-cycle.
//  One instance per ALU. out_pack/out_valid feed the ALU input packet port
//   directly.
// TESTING
//  T1 reset: hold reset_n=0 mid-stream -> out_valid=0, count=0, in_ready=1,
//   out_pack=='0 on the same cycle.
//  T2 latency/order: push A (rs1_value=32'h10, rs2_value=32'h20) at N, B at
//   N+1, out_ready=1 -> A at N+1, B at N+2, payload bit-exact.
//  T3 full: out_ready=0, push 4 packets -> count=4, in_ready=0. A fifth in_valid
//   is ignored; one pop -> in_ready=1 the next cycle; the 5th packet is accepted
//   after that.
//  T4 wrap: 10 pushes with out_ready toggling 1/0 each cycle -> all 10 emerged
//   in order; count never exceeds 4 or underflows.
//  T5 squash: count=3, assert squash together with in_valid and out_ready ->
//   next cycle count=0, out_valid=0. The squash-cycle push never appears.
//  T6 steady state: count=2, push+pop every cycle for 8 cycles -> count stays 2,
//   throughput 1 packet/cycle.

Source files
------------

// File: rtl/alu_issue_buffer_pkg.sv
// Shared types for the ALU issue path: operand data, decoded fields and the
// ISSUE_PACKET that travels from regfile read into the ALU functional units.
package alu_issue_buffer_pkg;

  localparam int unsigned ALU_ISSUE_BUF_DEPTH = 4;
  localparam int unsigned XLEN                = 32;
  localparam int unsigned PREG_IDX_W          = 6;

  typedef logic [XLEN-1:0] DATA;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLT  = 4'h2,
    ALU_SLTU = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9
  } ALU_FUNC;

  typedef enum logic [1:0] {
    OPA_IS_RS1  = 2'h0,
    OPA_IS_NPC  = 2'h1,
    OPA_IS_PC   = 2'h2,
    OPA_IS_ZERO = 2'h3
  } ALU_OPA_SELECT;

  typedef enum logic [2:0] {
    OPB_IS_RS2   = 3'h0,
    OPB_IS_I_IMM = 3'h1,
    OPB_IS_S_IMM = 3'h2,
    OPB_IS_B_IMM = 3'h3,
    OPB_IS_U_IMM = 3'h4,
    OPB_IS_J_IMM = 3'h5
  } ALU_OPB_SELECT;

  typedef struct packed {
    ALU_FUNC                 alu_func;
    ALU_OPA_SELECT           opa_select;
    ALU_OPB_SELECT           opb_select;
    logic [PREG_IDX_W-1:0]   dest_reg_idx;
    logic                    rd_mem;
    logic                    wr_mem;
    logic                    cond_branch;
    logic                    uncond_branch;
    logic                    halt;
    logic                    illegal;
    logic                    valid;
  } DECODED_VALS;

  typedef struct packed {
    DATA         PC;
    DATA         NPC;
    logic [31:0] inst;
    DATA         rs1_value;
    DATA         rs2_value;
    DECODED_VALS decoded_vals;
  } ISSUE_PACKET;

endpackage

// File: rtl/alu_issue_buffer.sv
// In-order flop-based FIFO between issue/regfile read and one ALU. Registered
// occupancy drives both handshakes, so there is no path from out_ready to in_ready.
module alu_issue_buffer
  import alu_issue_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = ALU_ISSUE_BUF_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  ISSUE_PACKET                in_pack,
  output logic                       in_ready,
  input  logic                       squash,
  output logic                       out_valid,
  output ISSUE_PACKET                out_pack,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  ISSUE_PACKET            r_mem [DEPTH];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;

  assign w_empty   = (r_count == '0);
  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = !w_empty;
  assign count     = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // Squash wins over any same-cycle push/pop: the buffer comes back exactly as
  // from reset and neither transfer is accounted for.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !squash) r_mem[r_tail] <= in_pack;
  end

  // Stale storage must never reach the ALU, so the head is masked when empty.
  always_comb begin
    out_pack = '0;
    if (!w_empty) out_pack = r_mem[r_head];
  end

  a_count_bound : assert property (@(posedge clock) disable iff (!reset_n)
    r_count <= FULL_CNT);

endmodule

// File: tb/tb_alu_issue_buffer.sv
// Self-checking bench for alu_issue_buffer against a queue-based FIFO model.
module tb_alu_issue_buffer;
  import alu_issue_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic            clock = 1'b0;
  logic            reset_n;
  logic            in_valid;
  ISSUE_PACKET     in_pack;
  logic            in_ready;
  logic            squash;
  logic            out_valid;
  ISSUE_PACKET     out_pack;
  logic            out_ready;
  logic [CW-1:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  ISSUE_PACKET mq[$];
  ISSUE_PACKET exp_pk;

  alu_issue_buffer #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_pack   (in_pack),
    .in_ready  (in_ready),
    .squash    (squash),
    .out_valid (out_valid),
    .out_pack  (out_pack),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clock = ~clock;

  function automatic ISSUE_PACKET rand_pkt();
    logic [$bits(ISSUE_PACKET)-1:0] v;
    for (int i = 0; i < $bits(ISSUE_PACKET); i++) v[i] = 1'($urandom_range(0, 1));
    return ISSUE_PACKET'(v);
  endfunction

  // Drive one cycle of inputs, clock it, then advance the reference queue.
  task automatic step(input logic v, input ISSUE_PACKET p, input logic ordy, input logic sq);
    int  sz;
    logic acc, rem;
    sz        = mq.size();
    in_valid  = v;
    in_pack   = p;
    out_ready = ordy;
    squash    = sq;
    acc = v && (sz < DEPTH);
    rem = ordy && (sz > 0);
    @(posedge clock);
    #1;
    if (sq) mq.delete();
    else begin
      if (rem) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    squash    = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_pack = '0; out_ready = 1'b0; squash = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1 || out_pack !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: valid=%b count=%0d ready=%b pack_zero=%b, want 0/0/1/1",
               out_valid, count, in_ready, out_pack == '0);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    mq.delete();
    step(1'b1, rand_pkt(), 1'b0, 1'b0);
    step(1'b1, rand_pkt(), 1'b0, 1'b0);
    n_checks++;
    if (count !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_prefill: count=%0d want 2", count);
    end
    reset_n = 1'b0;
    #2;
    mq.delete();
    n_checks++;
    if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1 || out_pack !== '0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b count=%0d ready=%b pack_zero=%b, want 0/0/1/1",
               out_valid, count, in_ready, out_pack == '0);
    end
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    exp_pk = rand_pkt();
    step(1'b1, exp_pk, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_pack !== exp_pk || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL reset_first_push: valid=%b count=%0d match=%b, want 1/1/1",
               out_valid, count, out_pack == exp_pk);
    end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_latency();
    ISSUE_PACKET a, b;
    a = rand_pkt(); a.rs1_value = 32'h10; a.rs2_value = 32'h20;
    b = rand_pkt();
    in_valid = 1'b1; in_pack = a; out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_pack !== '0) begin
      n_fail++;
      $display("FAIL no_flow_through: valid=%b pack_zero=%b, want 0/1", out_valid, out_pack == '0);
    end
    step(1'b1, a, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_pack !== a || out_pack.rs1_value !== 32'h10 ||
        out_pack.rs2_value !== 32'h20) begin
      n_fail++;
      $display("FAIL latency_A: valid=%b rs1=%h rs2=%h want 1/10/20", out_valid,
               out_pack.rs1_value, out_pack.rs2_value);
    end
    step(1'b1, b, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_pack !== b || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL latency_B: valid=%b count=%0d match=%b want 1/1/1", out_valid, count,
               out_pack == b);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || count !== '0 || out_pack !== '0) begin
      n_fail++;
      $display("FAIL latency_drain: valid=%b count=%0d want 0/0", out_valid, count);
    end
  endtask

  task automatic test_full();
    ISSUE_PACKET e;
    e = rand_pkt();
    for (int i = 0; i < DEPTH; i++) step(1'b1, rand_pkt(), 1'b0, 1'b0);
    n_checks++;
    if (count !== CW'(DEPTH) || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: count=%0d ready=%b want 4/0", count, in_ready);
    end
    step(1'b1, e, 1'b0, 1'b0);
    n_checks++;
    if (count !== CW'(DEPTH) || out_pack !== mq[0]) begin
      n_fail++;
      $display("FAIL full_ignore: count=%0d want 4", count);
    end
    step(1'b1, e, 1'b1, 1'b0);
    n_checks++;
    if (count !== CW'(DEPTH - 1) || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_frees: count=%0d ready=%b want 3/1", count, in_ready);
    end
    step(1'b1, e, 1'b0, 1'b0);
    n_checks++;
    if (count !== CW'(DEPTH) || mq[DEPTH-1] !== e) begin
      n_fail++;
      $display("FAIL full_fifth_accept: count=%0d want 4", count);
    end
    while (mq.size() != 0) begin
      exp_pk = mq[0];
      n_checks++;
      if (out_valid !== 1'b1 || out_pack !== exp_pk) begin
        n_fail++;
        $display("FAIL full_drain_order: valid=%b match=%b want 1/1", out_valid, out_pack == exp_pk);
      end
      step(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int popped = 0;
    int guard  = 0;
    logic ordy = 1'b1;
    while ((pushed < 10 || mq.size() != 0) && guard < 100) begin
      int sz;
      sz = mq.size();
      exp_pk = (sz != 0) ? mq[0] : '0;
      n_checks++;
      if (count !== CW'(sz) || count > CW'(DEPTH) || out_pack !== exp_pk) begin
        n_fail++;
        $display("FAIL wrap_cycle%0d: count=%0d want %0d, head_match=%b", guard, count, sz,
                 out_pack == exp_pk);
      end
      if (ordy && sz != 0) popped++;
      if (pushed < 10 && sz < DEPTH) begin
        pushed++;
        step(1'b1, rand_pkt(), ordy, 1'b0);
      end else begin
        step(1'b0, '0, ordy, 1'b0);
      end
      ordy = ~ordy;
      guard++;
    end
    n_checks++;
    if (popped != 10 || count !== '0) begin
      n_fail++;
      $display("FAIL wrap_total: popped=%0d count=%0d want 10/0", popped, count);
    end
  endtask

  task automatic test_squash();
    for (int i = 0; i < 3; i++) step(1'b1, rand_pkt(), 1'b0, 1'b0);
    n_checks++;
    if (count !== CW'(3)) begin
      n_fail++;
      $display("FAIL squash_prefill: count=%0d want 3", count);
    end
    step(1'b1, rand_pkt(), 1'b1, 1'b1);
    n_checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pack !== '0) begin
      n_fail++;
      $display("FAIL squash_flush: count=%0d valid=%b ready=%b want 0/0/1", count, out_valid, in_ready);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL squash_no_ghost: count=%0d valid=%b want 0/0", count, out_valid);
    end
  endtask

  task automatic test_steady();
    int pops = 0;
    step(1'b1, rand_pkt(), 1'b0, 1'b0);
    step(1'b1, rand_pkt(), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_pk = mq[0];
      n_checks++;
      if (out_valid !== 1'b1 || out_pack !== exp_pk) begin
        n_fail++;
        $display("FAIL steady_head%0d: valid=%b match=%b want 1/1", i, out_valid, out_pack == exp_pk);
      end
      if (out_valid === 1'b1) pops++;
      step(1'b1, rand_pkt(), 1'b1, 1'b0);
      n_checks++;
      if (count !== CW'(2)) begin
        n_fail++;
        $display("FAIL steady_count%0d: count=%0d want 2", i, count);
      end
    end
    n_checks++;
    if (pops != 8) begin
      n_fail++;
      $display("FAIL steady_throughput: pops=%0d want 8", pops);
    end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int sz;
      sz = mq.size();
      exp_pk = (sz != 0) ? mq[0] : '0;
      n_checks++;
      if (count !== CW'(sz) || out_valid !== (sz != 0) || in_ready !== (sz < DEPTH) ||
          out_pack !== exp_pk) begin
        n_fail++;
        $display("FAIL random_cycle%0d: count=%0d want %0d valid=%b ready=%b head_match=%b",
                 i, count, sz, out_valid, in_ready, out_pack == exp_pk);
      end
      step(1'($urandom_range(0, 1)), rand_pkt(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_wrap();
    test_squash();
    test_steady();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
